// File: rtl/score_display_ctrl.sv
// -----------------------------------------------------------------------------
// score_display_ctrl
//
// Sequencer for the two-digit seven-segment score display. It holds the BCD
// score counter and the session high score. It blinks the digits after game
// over, and it chooses whether the digits show the live score or the high score.
// TENS/UNITS/BLANK feed the segment decoder.
//
// Optional feature macro: SEG_HISCORE_EN
//   defined   : high-score register, HISHOW state and SHOW_HI handling present
//   undefined : no high score; SHOW_HI has no effect; HI_HOLD_CYCLES unused
//
// Parameters:
//   BLINK_CYCLES   - CLK cycles per BLANK half-period in OVER (>= 2)
//   HI_HOLD_CYCLES - CLK cycles the high score stays on screen (>= 2)
//
// Ports:
//   CLK        in   system clock
//   RST        in   synchronous, active-high reset
//   NEW_GAME   in   pulse: start/restart a game
//   SCORE_INC  in   pulse: add one point
//   GAME_OVER  in   pulse: end the current game
//   SHOW_HI    in   pulse: show the high score
//   TENS       out  BCD tens digit (registered)
//   UNITS      out  BCD units digit (registered)
//   BLANK      out  1 = both digits dark (registered)
// -----------------------------------------------------------------------------
module score_display_ctrl #(
  parameter int BLINK_CYCLES   = 12500000,
  parameter int HI_HOLD_CYCLES = 50000000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       NEW_GAME,
  input  logic       SCORE_INC,
  input  logic       GAME_OVER,
  input  logic       SHOW_HI,
  output logic [3:0] TENS,
  output logic [3:0] UNITS,
  output logic       BLANK
);

  // Elaboration-time sanity checks on the timing parameters.
  if (BLINK_CYCLES < 2) begin : g_bad_blink
    $error("score_display_ctrl: BLINK_CYCLES must be at least 2");
  end
  if (HI_HOLD_CYCLES < 2) begin : g_bad_hold
    $error("score_display_ctrl: HI_HOLD_CYCLES must be at least 2");
  end

  localparam int                 BLINK_W    = $clog2(BLINK_CYCLES);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

`ifdef SEG_HISCORE_EN
  localparam int                HOLD_W    = $clog2(HI_HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HI_HOLD_CYCLES - 1);
`endif

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PLAY,
    ST_OVER
`ifdef SEG_HISCORE_EN
    , ST_HISHOW
`endif
  } state_t;

  // The single pulse that wins this cycle. Lower-priority pulses are dropped.
  typedef enum logic [2:0] {
    EV_NONE,
    EV_NEW,
    EV_END,
    EV_INC,
    EV_HI
  } event_t;

  event_t ev;

  state_t             state_q, state_d;
  logic [3:0]         tens_q, tens_d;
  logic [3:0]         units_q, units_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blank_d;
  logic [3:0]         disp_tens_d, disp_units_d;

`ifdef SEG_HISCORE_EN
  logic [3:0]        hi_tens_q, hi_tens_d;
  logic [3:0]        hi_units_q, hi_units_d;
  state_t            ret_q, ret_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
`endif

  always_comb begin
    ev = EV_NONE;
    if (NEW_GAME)       ev = EV_NEW;
    else if (GAME_OVER) ev = EV_END;
    else if (SCORE_INC) ev = EV_INC;
    else if (SHOW_HI)   ev = EV_HI;
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d     = state_q;
    tens_d      = tens_q;
    units_d     = units_q;
    blink_cnt_d = blink_cnt_q;
    blank_d     = 1'b0;        // digits are only ever dark while blinking in OVER
`ifdef SEG_HISCORE_EN
    hi_tens_d  = hi_tens_q;
    hi_units_d = hi_units_q;
    ret_d      = ret_q;
    hold_cnt_d = hold_cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (ev == EV_NEW) begin
          state_d = ST_PLAY;
          tens_d  = 4'd0;
          units_d = 4'd0;
        end
`ifdef SEG_HISCORE_EN
        else if (ev == EV_HI) begin
          state_d    = ST_HISHOW;
          ret_d      = ST_IDLE;
          hold_cnt_d = '0;
        end
`endif
      end

      ST_PLAY: begin
        case (ev)
          EV_NEW: begin
            tens_d  = 4'd0;
            units_d = 4'd0;
          end
          EV_END: begin
            state_d     = ST_OVER;
            blink_cnt_d = '0;
`ifdef SEG_HISCORE_EN
            // Concatenated BCD compares as tens first, then units.
            if ({tens_q, units_q} > {hi_tens_q, hi_units_q}) begin
              hi_tens_d  = tens_q;
              hi_units_d = units_q;
            end
`endif
          end
          EV_INC: begin
            // Saturate at 99: no wrap back to 00.
            if (!(tens_q == 4'd9 && units_q == 4'd9)) begin
              if (units_q == 4'd9) begin
                units_d = 4'd0;
                tens_d  = tens_q + 4'd1;
              end else begin
                units_d = units_q + 4'd1;
              end
            end
          end
          default: ;
        endcase
      end

      ST_OVER: begin
        if (ev == EV_NEW) begin
          state_d = ST_PLAY;
          tens_d  = 4'd0;
          units_d = 4'd0;
        end
`ifdef SEG_HISCORE_EN
        else if (ev == EV_HI) begin
          state_d    = ST_HISHOW;
          ret_d      = ST_OVER;
          hold_cnt_d = '0;
        end
`endif
        else begin
          // BLANK itself holds the blink phase while in OVER.
          if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blank_d     = ~BLANK;
          end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
            blank_d     = BLANK;
          end
        end
      end

`ifdef SEG_HISCORE_EN
      ST_HISHOW: begin
        if (ev == EV_NEW) begin
          state_d = ST_PLAY;
          tens_d  = 4'd0;
          units_d = 4'd0;
        end else if (ev == EV_HI) begin
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HOLD_LAST) begin
          // Going back to OVER restarts the blink in the lit phase.
          state_d     = ret_q;
          hold_cnt_d  = '0;
          blink_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
`endif

      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from next-state values, so a pulse sampled on
    // an edge shows on the digits right after that same edge.
    disp_tens_d  = tens_d;
    disp_units_d = units_d;
`ifdef SEG_HISCORE_EN
    if (state_d == ST_HISHOW) begin
      disp_tens_d  = hi_tens_d;
      disp_units_d = hi_units_d;
    end
`endif
  end

  always_ff @(posedge CLK) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of statement order.
    if (RST) begin
      state_q     <= ST_IDLE;
      tens_q      <= 4'd0;
      units_q     <= 4'd0;
      blink_cnt_q <= '0;
      TENS        <= 4'd0;
      UNITS       <= 4'd0;
      BLANK       <= 1'b0;
`ifdef SEG_HISCORE_EN
      hi_tens_q  <= 4'd0;
      hi_units_q <= 4'd0;
      ret_q      <= ST_IDLE;
      hold_cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      tens_q      <= tens_d;
      units_q     <= units_d;
      blink_cnt_q <= blink_cnt_d;
      TENS        <= disp_tens_d;
      UNITS       <= disp_units_d;
      BLANK       <= blank_d;
`ifdef SEG_HISCORE_EN
      hi_tens_q  <= hi_tens_d;
      hi_units_q <= hi_units_d;
      ret_q      <= ret_d;
      hold_cnt_q <= hold_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_score_display_ctrl.sv
// -----------------------------------------------------------------------------
// tb_score_display_ctrl
//
// Directed bench for score_display_ctrl with BLINK_CYCLES=4, HI_HOLD_CYCLES=6.
// The driver applies one cycle of inputs at a time and queues the digits and
// BLANK expected right after the next rising edge. The monitor pops one entry
// per rising edge and compares on the following falling edge.
// -----------------------------------------------------------------------------
module tb_score_display_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       NEW_GAME = 1'b0;
  logic       SCORE_INC = 1'b0;
  logic       GAME_OVER = 1'b0;
  logic       SHOW_HI = 1'b0;
  logic [3:0] TENS;
  logic [3:0] UNITS;
  logic       BLANK;

  always #5 CLK = ~CLK;

  score_display_ctrl #(
    .BLINK_CYCLES  (4),
    .HI_HOLD_CYCLES(6)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .NEW_GAME (NEW_GAME),
    .SCORE_INC(SCORE_INC),
    .GAME_OVER(GAME_OVER),
    .SHOW_HI  (SHOW_HI),
    .TENS     (TENS),
    .UNITS    (UNITS),
    .BLANK    (BLANK)
  );

  typedef struct {
    logic [3:0] t;
    logic [3:0] u;
    logic       b;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // One clock of stimulus plus the expected display after that clock's edge.
  task automatic step(input int rst, input int ng, input int inc, input int go,
                      input int hi, input int et, input int eu, input int eb,
                      input string name);
    exp_t e;
    @(posedge CLK);
    #1;
    RST       = (rst != 0);
    NEW_GAME  = (ng != 0);
    SCORE_INC = (inc != 0);
    GAME_OVER = (go != 0);
    SHOW_HI   = (hi != 0);
    e.t    = 4'(et);
    e.u    = 4'(eu);
    e.b    = (eb != 0);
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic idle(input int n, input int et, input int eu, input int eb,
                      input string name);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, et, eu, eb, name);
  endtask

  task automatic incs(input int n, input string name);
    for (int i = 1; i <= n; i++) begin
      int v;
      v = (i > 99) ? 99 : i;
      step(0, 0, 1, 0, 0, v / 10, v % 10, 0, name);
    end
  endtask

  // Monitor: every cycle is an output presentation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge CLK);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        @(negedge CLK);
        checks++;
        if (TENS !== e.t || UNITS !== e.u || BLANK !== e.b) begin
          failures++;
          $display("FAIL %s: got %0d%0d blank=%0b, expected %0d%0d blank=%0b",
                   e.name, TENS, UNITS, BLANK, e.t, e.u, e.b);
        end
      end
    end
  end

  initial begin : driver
    // 1. Reset, then IDLE ignores SCORE_INC.
    step(1, 0, 0, 0, 0, 0, 0, 0, "reset");
    step(1, 0, 0, 0, 0, 0, 0, 0, "reset");
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 0, 0, 0, "idle_inc_ignored");

    // 2. Units rollover into tens.
    step(0, 1, 0, 0, 0, 0, 0, 0, "new_game");
    incs(10, "rollover");

    // 3. Saturation at 99.
    step(0, 1, 0, 0, 0, 0, 0, 0, "new_game");
    incs(105, "saturate");

    // 4. Blink at 23, then restart.
    step(0, 1, 0, 0, 0, 0, 0, 0, "new_game");
    incs(23, "count_to_23");
    step(0, 0, 0, 1, 0, 2, 3, 0, "blink_enter");
    idle(3, 2, 3, 0, "blink_lit");
    idle(4, 2, 3, 1, "blink_dark");
    idle(4, 2, 3, 0, "blink_lit2");
    step(0, 1, 0, 0, 0, 0, 0, 0, "blink_new_game");

    // 5. Second game ends at 15; high score remains 23.
    incs(15, "count_to_15");
    step(0, 0, 0, 1, 0, 1, 5, 0, "over_15");
    idle(2, 1, 5, 0, "over_15_lit");
`ifdef SEG_HISCORE_EN
    step(0, 0, 0, 0, 1, 2, 3, 0, "hi_show");
    idle(3, 2, 3, 0, "hi_hold");
    step(0, 0, 0, 0, 1, 2, 3, 0, "hi_restart");
    idle(5, 2, 3, 0, "hi_hold_after_restart");
    idle(4, 1, 5, 0, "hi_return_lit");
    idle(4, 1, 5, 1, "hi_return_dark");
`else
    step(0, 0, 0, 0, 1, 1, 5, 0, "hi_ignored");
    idle(4, 1, 5, 1, "hi_ignored_dark");
    idle(4, 1, 5, 0, "hi_ignored_lit");
`endif

    // 6. Same-cycle collision: NEW_GAME wins, stays in PLAY.
    step(0, 1, 0, 0, 0, 0, 0, 0, "new_game");
    incs(7, "count_to_7");
    step(0, 1, 1, 1, 0, 0, 0, 0, "collision");
    step(0, 0, 1, 0, 0, 0, 1, 0, "collision_still_play");

    // Reset mid-blink with BLANK=1; RST overrides the other pulses.
    step(0, 0, 0, 1, 0, 0, 1, 0, "over_01");
    idle(3, 0, 1, 0, "over_01_lit");
    idle(1, 0, 1, 1, "over_01_dark");
    step(1, 1, 1, 0, 1, 0, 0, 0, "reset_mid_blink");
    step(0, 0, 1, 0, 0, 0, 0, 0, "reset_to_idle");
    step(0, 0, 0, 0, 1, 0, 0, 0, "hi_cleared");
    idle(5, 0, 0, 0, "hi_cleared_hold");
    step(0, 1, 0, 0, 0, 0, 0, 0, "post_reset_new_game");
    step(0, 0, 1, 0, 0, 0, 1, 0, "post_reset_inc");
    idle(1, 0, 1, 0, "final_idle");

    // Bounded drain of the scoreboard.
    repeat (4) @(negedge CLK);
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d unchecked entries, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
